pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports and the PC register.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, the PC value loaded at reset.
REQ-003 SHALL have parameter FETCH_WIDTH, default 1, instructions per fetch (legal: 1, 2, 4); the sequential stride is 4*FETCH_WIDTH bytes.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port stall, input, 1 bit: pipeline stall; blocks sequential advance and branch application.
REQ-007 SHALL have port exc_en, input, 1 bit: exception/flush redirect request.
REQ-008 SHALL have port exc_addr, input, ADDR_WIDTH bits: exception target.
REQ-009 SHALL have port branch_en, input, 1 bit: branch redirect request.
REQ-010 SHALL have port branch_addr, input, ADDR_WIDTH bits: branch target.
REQ-011 SHALL have port fetch_ready, input, 1 bit: instruction memory accepts the current request.
REQ-012 SHALL have port fetch_valid, output, 1 bit: fetch request valid; replaces the legacy rom_en.
REQ-013 SHALL have port addr, output, ADDR_WIDTH bits: current fetch address.
REQ-014 SHALL have port pc_misalign, output, 1 bit: current addr is misaligned.

Function
REQ-015 SHALL implement states BOOT, FETCH and PEND.
- BOOT: fetch_valid=0.
- FETCH: fetch_valid=1, no redirect pending.
- PEND: fetch_valid=1, branch redirect latched.
REQ-016 SHALL leave BOOT for FETCH unconditionally on the first rising edge after rst deasserts, so the first request appears one cycle after release.
REQ-017 SHALL define accept = fetch_valid & fetch_ready & !stall.
REQ-018 SHALL set next sequential addr = (addr with low log2(4*FETCH_WIDTH) bits cleared) + 4*FETCH_WIDTH, modulo 2^ADDR_WIDTH (wraps from all-ones to 0).
REQ-019 SHALL give redirect priority exception > pending branch > new branch > sequential.
REQ-020 SHALL load exc_addr on the next edge whenever exc_en=1 in FETCH or PEND, regardless of stall or fetch_ready; it SHALL clear any pending branch and go to FETCH.
REQ-021 SHALL load branch_addr on the next edge on branch_en=1 with accept=1 (no exc_en), and stay in FETCH.
REQ-022 SHALL latch branch_addr into a pending register on branch_en=1 with accept=0 (no exc_en), go to PEND, and hold addr.
REQ-023 SHALL in PEND load the pending target on the first accept and return to FETCH.
REQ-024 SHALL in PEND overwrite the pending target with a newer branch_en, keeping the newest.
REQ-025 SHALL advance addr to the next sequential value only on accept with no redirect.
REQ-026 SHALL otherwise hold addr and fetch_valid stable while fetch_valid=1 and accept=0.
REQ-027 SHALL ignore exc_en and branch_en in BOOT.

Reset
REQ-028 SHALL while rst=0 asynchronously force state=BOOT, addr=RESET_VECTOR, fetch_valid=0, pc_misalign=0, and pending register and pending flag to 0.
REQ-029 SHALL when reset is asserted mid-PEND discard the pending branch; no redirect survives reset.

Configuration
REQ-030 SHALL use macro PC_MISALIGN_CHECK_EN.
REQ-031 SHALL when PC_MISALIGN_CHECK_EN is defined:
- set pc_misalign=1 whenever addr[1:0]!=0;
- force fetch_valid=0 while pc_misalign=1;
- hold addr while pc_misalign=1;
- allow only exc_en to leave the misaligned condition.
REQ-032 SHALL when PC_MISALIGN_CHECK_EN is undefined:
- force bits [1:0] of every loaded redirect target to 0;
- tie pc_misalign to 0.

Verification
REQ-033 SHALL cover reset/boot: RESET_VECTOR=0xBFC00000, release rst -> fetch_valid=0 for 1 cycle, then 1 with addr=0xBFC00000, then 0xBFC00004 after one accept.
REQ-034 SHALL cover stride: FETCH_WIDTH=2, redirect to 0x1004, fetch_ready=1 -> next addr 0x1008, then 0x1010.
REQ-035 SHALL cover a stalled branch: stall=1 with branch_en=1 to 0x2000 for 1 cycle -> state PEND, addr held; stall=0 with fetch_ready=1 -> addr=0x2000 next cycle, then FETCH.
REQ-036 SHALL cover simultaneous redirects: exc_en=1 to 0x80 with branch_en=1 to 0x2000 while stall=1 and a branch pending -> addr=0x80 next cycle, pending cleared.
REQ-037 SHALL cover wrap: ADDR_WIDTH=32, addr=0xFFFFFFFC, accept -> addr=0x00000000.
REQ-038 SHALL cover misalignment: with the macro, branch to 0x1002 -> pc_misalign=1 and fetch_valid=0 until exc_en to 0x80; without it -> addr=0x1000 and pc_misalign=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: boot, sequential fetch and branch/exception redirect.
// Optional PC_MISALIGN_CHECK_EN flags misaligned fetch addresses instead of masking them.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FETCH_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  exc_en,
  input  logic [ADDR_WIDTH-1:0] exc_addr,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  pc_misalign
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    PEND
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(4 * FETCH_WIDTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic                    pend;
  logic                    accept;
  logic                    mis;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   tgt_raw;
  logic [ADDR_WIDTH-1:0]   tgt;
  logic [ADDR_WIDTH-1:0]   seq_addr;

  assign accept   = fetch_valid & fetch_ready & ~stall;
  assign seq_addr = (addr & ~(STRIDE - 1'b1)) + STRIDE;

`ifdef PC_MISALIGN_CHECK_EN
  assign mis = pc_misalign;
  assign tgt = tgt_raw;
`else
  assign mis         = 1'b0;
  assign pc_misalign = 1'b0;
  assign tgt         = tgt_raw & ~ADDR_WIDTH'(3);
`endif

  // Redirect select: exception > pending branch > new branch
  always_comb begin
    load    = 1'b0;
    tgt_raw = exc_addr;
    if (state != BOOT) begin
      if (exc_en) begin
        load = 1'b1;
      end else if (!mis) begin
        if (pend && accept) begin
          load    = 1'b1;
          tgt_raw = pend_addr;
        end else if (state == FETCH && branch_en && accept) begin
          load    = 1'b1;
          tgt_raw = branch_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      addr        <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      pend_addr   <= '0;
      pend        <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      pc_misalign <= 1'b0;
`endif
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
`ifdef PC_MISALIGN_CHECK_EN
          pc_misalign <= |addr[1:0];
          fetch_valid <= ~|addr[1:0];
`else
          fetch_valid <= 1'b1;
`endif
        end
        FETCH, PEND: begin
          if (load) begin
            addr      <= tgt;
            pend      <= 1'b0;
            pend_addr <= '0;
            state     <= FETCH;
`ifdef PC_MISALIGN_CHECK_EN
            pc_misalign <= |tgt[1:0];
            fetch_valid <= ~|tgt[1:0];
`else
            fetch_valid <= 1'b1;
`endif
          end else if (!mis && branch_en) begin
            pend_addr <= branch_addr;
            pend      <= 1'b1;
            state     <= PEND;
          end else if (!mis && accept) begin
            addr <= seq_addr;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: two instances (FETCH_WIDTH 1 and 2) share stimulus.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exc_en;
  logic [31:0] exc_addr;
  logic        branch_en;
  logic [31:0] branch_addr;
  logic        fetch_ready;
  logic        fv1, fv2, mis1, mis2;
  logic [31:0] a1, a2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'hBFC0_0000),
    .FETCH_WIDTH (1)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .exc_en     (exc_en),
    .exc_addr   (exc_addr),
    .branch_en  (branch_en),
    .branch_addr(branch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fv1),
    .addr       (a1),
    .pc_misalign(mis1)
  );

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'hBFC0_0000),
    .FETCH_WIDTH (2)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .exc_en     (exc_en),
    .exc_addr   (exc_addr),
    .branch_en  (branch_en),
    .branch_addr(branch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fv2),
    .addr       (a2),
    .pc_misalign(mis2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] e1,
                           input logic [31:0] e2, input logic v,
                           input logic m);
    check({tag, "_addr1"}, a1, e1);
    check({tag, "_addr2"}, a2, e2);
    check({tag, "_valid1"}, {31'b0, fv1}, {31'b0, v});
    check({tag, "_valid2"}, {31'b0, fv2}, {31'b0, v});
    check({tag, "_mis1"}, {31'b0, mis1}, {31'b0, m});
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    exc_en      = 1'b0;
    exc_addr    = '0;
    branch_en   = 1'b0;
    branch_addr = '0;
    fetch_ready = 1'b0;
    #12;
    expect_pc("reset", 32'hBFC0_0000, 32'hBFC0_0000, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b1;
    #1;
    expect_pc("boot", 32'hBFC0_0000, 32'hBFC0_0000, 1'b0, 1'b0);
    tick;
    expect_pc("first", 32'hBFC0_0000, 32'hBFC0_0000, 1'b1, 1'b0);
    fetch_ready = 1'b1;
    tick;
    expect_pc("seq", 32'hBFC0_0004, 32'hBFC0_0008, 1'b1, 1'b0);
    fetch_ready = 1'b0;
    tick;
    expect_pc("hold", 32'hBFC0_0004, 32'hBFC0_0008, 1'b1, 1'b0);

    // stride from an unaligned-to-stride target
    exc_en   = 1'b1;
    exc_addr = 32'h1004;
    tick;
    expect_pc("exc1004", 32'h1004, 32'h1004, 1'b1, 1'b0);
    exc_en      = 1'b0;
    fetch_ready = 1'b1;
    tick;
    expect_pc("stride1", 32'h1008, 32'h1008, 1'b1, 1'b0);
    tick;
    expect_pc("stride2", 32'h100C, 32'h1010, 1'b1, 1'b0);

    // stalled branch goes pending, applied on next accept
    stall       = 1'b1;
    branch_en   = 1'b1;
    branch_addr = 32'h2000;
    tick;
    expect_pc("stall_br", 32'h100C, 32'h1010, 1'b1, 1'b0);
    stall     = 1'b0;
    branch_en = 1'b0;
    tick;
    expect_pc("pend_load", 32'h2000, 32'h2000, 1'b1, 1'b0);
    tick;
    expect_pc("after_pend", 32'h2004, 32'h2008, 1'b1, 1'b0);

    // exception beats pending and new branch
    fetch_ready = 1'b0;
    stall       = 1'b1;
    branch_en   = 1'b1;
    branch_addr = 32'h3000;
    tick;
    expect_pc("pend2", 32'h2004, 32'h2008, 1'b1, 1'b0);
    exc_en      = 1'b1;
    exc_addr    = 32'h80;
    branch_addr = 32'h2000;
    tick;
    expect_pc("exc_prio", 32'h80, 32'h80, 1'b1, 1'b0);
    exc_en      = 1'b0;
    branch_en   = 1'b0;
    stall       = 1'b0;
    fetch_ready = 1'b1;
    tick;
    expect_pc("pend_clr", 32'h84, 32'h88, 1'b1, 1'b0);

    // wrap at top of address space
    fetch_ready = 1'b0;
    exc_en      = 1'b1;
    exc_addr    = 32'hFFFF_FFFC;
    tick;
    expect_pc("top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0);
    exc_en      = 1'b0;
    fetch_ready = 1'b1;
    tick;
    expect_pc("wrap", 32'h0, 32'h0, 1'b1, 1'b0);

    // misaligned branch target
    branch_en   = 1'b1;
    branch_addr = 32'h1002;
    tick;
    branch_en = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    expect_pc("mis_br", 32'h1002, 32'h1002, 1'b0, 1'b1);
    tick;
    expect_pc("mis_hold", 32'h1002, 32'h1002, 1'b0, 1'b1);
`else
    expect_pc("mis_br", 32'h1000, 32'h1000, 1'b1, 1'b0);
    tick;
    expect_pc("mis_seq", 32'h1004, 32'h1008, 1'b1, 1'b0);
`endif
    exc_en   = 1'b1;
    exc_addr = 32'h80;
    tick;
    expect_pc("mis_exit", 32'h80, 32'h80, 1'b1, 1'b0);
    exc_en = 1'b0;

    // reset mid-PEND discards the pending branch
    fetch_ready = 1'b0;
    branch_en   = 1'b1;
    branch_addr = 32'h4000;
    tick;
    branch_en = 1'b0;
    rst       = 1'b0;
    #2;
    expect_pc("async_rst", 32'hBFC0_0000, 32'hBFC0_0000, 1'b0, 1'b0);
    tick;
    rst      = 1'b1;
    exc_en   = 1'b1;
    exc_addr = 32'h500;
    tick;
    expect_pc("boot_ign_exc", 32'hBFC0_0000, 32'hBFC0_0000, 1'b1, 1'b0);
    exc_en      = 1'b0;
    fetch_ready = 1'b1;
    tick;
    expect_pc("no_stale", 32'hBFC0_0004, 32'hBFC0_0008, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
